y_win3x3: RTL and testbench
===========================

// Module: y_win3x3
// PURPOSE
// - Builds a 3x3 luma neighbourhood window from the 8-bit Y stream produced by the rgb2y stage.
// - Two on-chip line buffers hold the previous two lines; a 3-deep column shift register per row holds the newest three pixels.
// - Feeds downstream Sobel/box-filter kernels.
// - Timing signals dv/hs/vs/line_end are delayed by the same latency as the window.
// PARAMETERS
// - COLORDEPTH  8     bits per luma sample
// - MAX_WIDTH   2048  maximum active pixels per line (line buffer depth)
// - ADDR_W      11    $clog2(MAX_WIDTH), column address width
// PORTS
// - clk         in   1            system clock (single clock domain)
// - rst         in   1            synchronous, active-high reset
// - y_i         in   COLORDEPTH   luma sample, meaningful only when dv_i=1
// - dv_i        in   1            data valid
// - hs_i        in   1            hsync
// - vs_i        in   1            vsync; rising edge = start of frame
// - line_end_i  in   1            high together with the last dv_i=1 pixel of a line
// - win_o       out  9*COLORDEPTH window; [8*CD +: CD]=row-2/col-2 ... [0 +: CD]=newest pixel (row0,col0)
// - win_full_o  out  1            window lies fully inside the frame (row_cnt>=2 && col_cnt>=2)
// - dv_o, hs_o, vs_o, line_end_o  out 1 each   inputs delayed by LAT=2
// - ovf_o       out  1            sticky: a line exceeded MAX_WIDTH; cleared on vs_i rising edge
// BEHAVIOUR
// - Reset: win_o=0, win_full_o=0, dv_o=hs_o=vs_o=line_end_o=0, ovf_o=0, col_cnt=0, row_cnt=0. Line buffer contents are not reset.
// - Latency: LAT=2 cycles from input pixel to the window containing it as win_o[0 +: CD].
//   - cycle 0: read lb0[col], lb1[col].
//   - cycle 1: RAM data valid; shift registers update.
//   - cycle 2: registered outputs.
// - Line buffers:
//   - On dv_i: lb0[col] <= y_i.
//   - One cycle later, lb1[col_d1] <= lb0 read data; col_d1 is the registered address.
//   - Read-before-write on the same address is required: the RAM returns the old data.
// - col_cnt (ADDR_W bits):
//   - Increments on each dv_i=1.
//   - Returns to 0 on dv_i & line_end_i.
//   - Saturates at MAX_WIDTH-1. Further dv_i in the same line do not write the buffers and set ovf_o.
// - row_cnt (2 bits, saturating at 2):
//   - Increments on dv_i & line_end_i.
//   - Cleared to 0 on vs_i rising edge; the vs_i edge detector is reset to 0.
// - Column shift registers:
//   - Advance only when the delayed dv (dv_d1)=1.
//   - Cleared to 0 at line start, i.e. the first dv after line_end, so stale pixels never appear at col<2.
// - Rows not yet present (row_cnt<2) output 0 in their window lanes.
//   - win_full_o is the only qualifier downstream uses for full windows.
// - dv_i=0 cycles: counters hold; win_o holds its last value; dv_o=0.
// - Simultaneous vs_i rise and dv_i: row_cnt clears first, and the pixel counts as row 0 of the new frame.
// - Reset mid-line: all state returns to reset values. Processing restarts cleanly at the next vs_i rise; partial lines before that give win_full_o=0.
// - Widths: no arithmetic on samples. Only counters; compare with ADDR_W-wide constants.
// STRUCTURE
// - Shared package (vid_pkg):
//   - COLORDEPTH and MAX_WIDTH defaults.
//   - typedef logic [COLORDEPTH-1:0] pix_t.
//   - typedef pix_t win3x3_t [3][3], plus the flatten/unflatten convention for win_o lane order.
//   - typedef struct {dv, hs, vs, line_end} vsync_t, the sync bundle used by all stages.
// - Sub-module line_buf:
//   - Simple dual-port RAM, 1 write port and 1 read port, 1-cycle registered read, read-before-write.
//   - Instantiated twice (lb0, lb1) so synthesis infers block RAM.
// - Sync delay: a single LAT-deep shift register of vsync_t.
// TESTING
// - Reset:
//   - Stimulus: assert rst 3 cycles mid-stream.
//   - Required: all outputs 0 the cycle after; ovf_o=0; win_full_o stays 0 until the third line after the next vs rise.
// - Ramp frame:
//   - Stimulus: 8x4 frame with y=16*row+col, line_end on col 7, 4 blank cycles between lines.
//   - Required: at row2,col2, 2 cycles later, win_o = {00,01,02,10,11,12,20,21,22} hex, MSB lane first, with win_full_o=1.
// - Border:
//   - Stimulus: same frame.
//   - Required: on row0, rows 1 and 2 lanes = 0 and win_full_o=0. At col0/col1 of any row, win_full_o=0 and the col lanes left of the pixel = 0.
// - Sync alignment:
//   - Stimulus: random hs/vs/dv patterns.
//   - Required: dv_o/hs_o/vs_o/line_end_o equal the inputs delayed exactly 2 cycles. The line_end_o pulse coincides with the last dv_o of the line.
// - Overflow:
//   - Stimulus: MAX_WIDTH=8 and a 10-pixel line.
//   - Required: ovf_o=1 from the 9th pixel onward; lb contents for cols 0..7 unchanged by pixels 8..9; ovf_o clears at the next vs_i rise.
// - Frame restart:
//   - Stimulus: vs_i rise after 2 lines of a frame, then a new frame with y=0xAA.
//   - Required: win_full_o stays 0 for new rows 0..1; the first full window contains only 0xAA, with no stale data.

Source files
------------

// File: rtl/y_win3x3_pkg.sv
// rtl/y_win3x3_pkg.sv - shared video types, defaults and window lane convention
package y_win3x3_pkg;

   localparam int CD_DEFAULT        = 8;
   localparam int MAX_WIDTH_DEFAULT = 2048;
   localparam int LAT               = 2;

   typedef logic [CD_DEFAULT-1:0] pix_t;
   typedef pix_t win3x3_t [3][3];

   typedef struct packed {
      logic dv;
      logic hs;
      logic vs;
      logic line_end;
   } vsync_t;

   // Flattened window lane for row offset r (0 = newest row) and column offset c (0 = newest column).
   function automatic int lane_idx(input int r, input int c);
      return r * 3 + c;
   endfunction

endpackage

// File: rtl/y_win3x3_if.sv
// rtl/y_win3x3_if.sv - luma stream in, 3x3 window and delayed sync out
interface y_win3x3_if #(
   parameter int COLORDEPTH = 8
);
   logic [COLORDEPTH-1:0]   y_i;
   logic                    dv_i;
   logic                    hs_i;
   logic                    vs_i;
   logic                    line_end_i;
   logic [9*COLORDEPTH-1:0] win_o;
   logic                    win_full_o;
   logic                    dv_o;
   logic                    hs_o;
   logic                    vs_o;
   logic                    line_end_o;
   logic                    ovf_o;

   modport master (
      output y_i, dv_i, hs_i, vs_i, line_end_i,
      input  win_o, win_full_o, dv_o, hs_o, vs_o, line_end_o, ovf_o
   );

   modport slave (
      input  y_i, dv_i, hs_i, vs_i, line_end_i,
      output win_o, win_full_o, dv_o, hs_o, vs_o, line_end_o, ovf_o
   );
endinterface

// File: rtl/y_win3x3_line_buf.sv
// rtl/y_win3x3_line_buf.sv - simple dual-port line RAM, registered read, read-before-write
module y_win3x3_line_buf #(
   parameter int W     = 8,
   parameter int DEPTH = 2048,
   parameter int AW    = 11
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/y_win3x3.sv
// rtl/y_win3x3.sv - 3x3 luma window builder: two line buffers, column shift registers, LAT=2
module y_win3x3
   import y_win3x3_pkg::*;
#(
   parameter int COLORDEPTH = CD_DEFAULT,
   parameter int MAX_WIDTH  = MAX_WIDTH_DEFAULT,
   parameter int ADDR_W     = $clog2(MAX_WIDTH)
) (
   input logic       clk,
   input logic       rst,
   y_win3x3_if.slave vid
);
   localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(MAX_WIDTH - 1);

   typedef logic [COLORDEPTH-1:0] sample_t;

   logic              vs_q;
   logic              vs_rise;
   logic [ADDR_W-1:0] col_cnt, col_eff, col_nxt, col_d1;
   logic [1:0]        row_cnt, row_eff, row_nxt, row_d1;
   logic              line_full, line_full_eff, line_full_nxt;
   logic              ovf, ovf_nxt;
   logic              lb_we, we_d1, dv_d1;
   logic              first;
   logic              win_full;
   sample_t           y_d1, lb0_rd, lb1_rd;
   sample_t           col_new [3];
   sample_t           sr [3][3];
   logic [9*COLORDEPTH-1:0] win_flat;
   vsync_t            sync_d [LAT];

   // A vs rise takes effect before the pixel of the same cycle, so that pixel is row 0, col 0.
   always_comb begin
      vs_rise       = vid.vs_i & ~vs_q;
      col_eff       = vs_rise ? '0 : col_cnt;
      row_eff       = vs_rise ? 2'd0 : row_cnt;
      line_full_eff = vs_rise ? 1'b0 : line_full;
      col_nxt       = col_eff;
      row_nxt       = row_eff;
      line_full_nxt = line_full_eff;
      lb_we         = vid.dv_i & ~line_full_eff;
      ovf_nxt       = (vs_rise ? 1'b0 : ovf) | (vid.dv_i & line_full_eff);
      if (vid.dv_i) begin
         if (vid.line_end_i) begin
            col_nxt       = '0;
            line_full_nxt = 1'b0;
            if (row_eff != 2'd2) begin
               row_nxt = row_eff + 2'd1;
            end
         end else if (col_eff == COL_LAST) begin
            line_full_nxt = 1'b1;
         end else begin
            col_nxt = col_eff + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q      <= 1'b0;
         col_cnt   <= '0;
         row_cnt   <= 2'd0;
         line_full <= 1'b0;
         ovf       <= 1'b0;
         dv_d1     <= 1'b0;
         we_d1     <= 1'b0;
         col_d1    <= '0;
         row_d1    <= 2'd0;
         y_d1      <= '0;
      end else begin
         vs_q      <= vid.vs_i;
         col_cnt   <= col_nxt;
         row_cnt   <= row_nxt;
         line_full <= line_full_nxt;
         ovf       <= ovf_nxt;
         dv_d1     <= vid.dv_i;
         we_d1     <= lb_we;
         col_d1    <= col_eff;
         row_d1    <= row_eff;
         y_d1      <= vid.y_i;
      end
   end

   // lb0 holds the previous line; lb1 receives lb0's old contents one cycle later.
   y_win3x3_line_buf #(.W(COLORDEPTH), .DEPTH(MAX_WIDTH), .AW(ADDR_W)) lb0 (
      .clk     (clk),
      .wr_en   (lb_we),
      .wr_addr (col_eff),
      .wr_data (vid.y_i),
      .rd_addr (col_eff),
      .rd_data (lb0_rd)
   );

   y_win3x3_line_buf #(.W(COLORDEPTH), .DEPTH(MAX_WIDTH), .AW(ADDR_W)) lb1 (
      .clk     (clk),
      .wr_en   (we_d1),
      .wr_addr (col_d1),
      .wr_data (lb0_rd),
      .rd_addr (col_eff),
      .rd_data (lb1_rd)
   );

   always_comb begin
      first      = (col_d1 == '0);
      col_new[0] = y_d1;
      col_new[1] = (row_d1 >= 2'd1) ? lb0_rd : '0;
      col_new[2] = (row_d1 >= 2'd2) ? lb1_rd : '0;
   end

   // Clearing older columns at line start keeps the previous line's tail out of col 0/1 windows.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               sr[r][c] <= '0;
            end
         end
         win_full <= 1'b0;
      end else if (dv_d1) begin
         for (int r = 0; r < 3; r++) begin
            sr[r][0] <= col_new[r];
            sr[r][1] <= first ? '0 : sr[r][0];
            sr[r][2] <= first ? '0 : sr[r][1];
         end
         win_full <= (row_d1 >= 2'd2) && (col_d1 >= ADDR_W'(2));
      end
   end

   always_comb begin
      win_flat = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            win_flat[lane_idx(r, c)*COLORDEPTH +: COLORDEPTH] = sr[r][c];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            sync_d[i] <= '0;
         end
      end else begin
         sync_d[0] <= {vid.dv_i, vid.hs_i, vid.vs_i, vid.line_end_i};
         for (int i = 1; i < LAT; i++) begin
            sync_d[i] <= sync_d[i-1];
         end
      end
   end

   assign vid.win_o      = win_flat;
   assign vid.win_full_o = win_full;
   assign vid.dv_o       = sync_d[LAT-1].dv;
   assign vid.hs_o       = sync_d[LAT-1].hs;
   assign vid.vs_o       = sync_d[LAT-1].vs;
   assign vid.line_end_o = sync_d[LAT-1].line_end;
   assign vid.ovf_o      = ovf;
endmodule

// File: tb/tb_y_win3x3.sv
// tb/tb_y_win3x3.sv - scoreboard bench for the 3x3 luma window builder
module tb_y_win3x3;
   import y_win3x3_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   y_win3x3_if #(.COLORDEPTH(8)) bus ();

   y_win3x3 #(.COLORDEPTH(8), .MAX_WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .vid (bus)
   );

   typedef struct {
      logic [71:0] win;
      logic        full;
      logic        care;
   } exp_t;

   exp_t       exp_q[$];
   vsync_t     hist[$];
   int         n_cmp = 0;
   int         n_mis = 0;
   logic [7:0] img [16][W];
   int         m_row = 0;
   int         m_col = 0;
   logic       m_vs = 1'b0;
   logic       care_win = 1'b1;
   exp_t       mon_e;
   vsync_t     mon_s;

   task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Drives one cycle; pixels feed a frame image from which the expected window is built.
   task automatic drive(input logic [7:0] y, input logic dv, input logic hs, input logic vs, input logic le);
      exp_t e;
      @(posedge clk);
      #1;
      bus.y_i = y; bus.dv_i = dv; bus.hs_i = hs; bus.vs_i = vs; bus.line_end_i = le;
      if (vs && !m_vs) begin
         m_row = 0;
         m_col = 0;
      end
      m_vs = vs;
      if (dv) begin
         e.care = care_win && (m_col < W) && (m_row < 16);
         e.win  = '0;
         e.full = 1'b0;
         if (e.care) begin
            img[m_row][m_col] = y;
            for (int ri = 0; ri < 3; ri++) begin
               for (int ci = 0; ci < 3; ci++) begin
                  if (m_row >= ri && m_col >= ci) begin
                     e.win[(ri*3+ci)*8 +: 8] = img[m_row-ri][m_col-ci];
                  end
               end
            end
            e.full = (m_row >= 2) && (m_col >= 2);
         end
         exp_q.push_back(e);
         if (le) begin
            m_row++;
            m_col = 0;
         end else begin
            m_col++;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic vs_start();
      drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Pixels past W get values the window must never show; ovf_o seen now reflects the previous drive.
   task automatic line(input int n, input int row, input bit aa, input bit chk_ovf);
      int idx = 0;
      logic [7:0] y;
      for (int c = 0; c < n + 4; c++) begin
         if (c < n) begin
            y = aa ? 8'hAA : (c < W ? 8'(16*row + c) : 8'(8'hE0 + c));
            drive(y, 1'b1, 1'b0, 1'b0, c == n - 1);
         end else begin
            drive(8'h00, 1'b0, (c - n) < 2, 1'b0, 1'b0);
         end
         if (chk_ovf && idx > 0) check("ovf_from_9th", 72'(bus.ovf_o), 72'(idx >= 9));
         idx++;
      end
   endtask

   task automatic frame(input int rows, input bit aa);
      vs_start();
      for (int r = 0; r < rows; r++) line(W, r, aa, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.y_i = '0; bus.dv_i = 1'b0; bus.hs_i = 1'b0; bus.vs_i = 1'b0; bus.line_end_i = 1'b0;
      m_row = 0; m_col = 0; m_vs = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check("rst_win_o",      bus.win_o,              72'h0);
      check("rst_win_full_o", 72'(bus.win_full_o),    72'h0);
      check("rst_dv_o",       72'(bus.dv_o),          72'h0);
      check("rst_hs_o",       72'(bus.hs_o),          72'h0);
      check("rst_vs_o",       72'(bus.vs_o),          72'h0);
      check("rst_line_end_o", 72'(bus.line_end_o),    72'h0);
      check("rst_ovf_o",      72'(bus.ovf_o),         72'h0);
   endtask

   // Sync outputs against inputs two cycles back; windows popped from the scoreboard on dv_o.
   always @(negedge clk) begin
      if (rst) begin
         hist.delete();
         exp_q.delete();
      end else begin
         if (hist.size() == 2) begin
            mon_s = hist.pop_front();
            check("dv_o",       72'(bus.dv_o),       72'(mon_s.dv));
            check("hs_o",       72'(bus.hs_o),       72'(mon_s.hs));
            check("vs_o",       72'(bus.vs_o),       72'(mon_s.vs));
            check("line_end_o", 72'(bus.line_end_o), 72'(mon_s.line_end));
         end
         hist.push_back({bus.dv_i, bus.hs_i, bus.vs_i, bus.line_end_i});
         if (bus.dv_o) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", 72'(bus.dv_o), 72'h0);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.care) begin
                  check("win_o",      bus.win_o,           mon_e.win);
                  check("win_full_o", 72'(bus.win_full_o), 72'(mon_e.full));
               end
            end
         end
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.y_i = '0; bus.dv_i = 1'b0; bus.hs_i = 1'b0; bus.vs_i = 1'b0; bus.line_end_i = 1'b0;
      do_reset();
      check_reset_outputs();

      // Ramp frame 8x4
      frame(4, 1'b0);

      // Random sync patterns; only sync alignment is judged here
      care_win = 1'b0;
      for (int i = 0; i < 300; i++) begin
         bit dv;
         dv = 1'($urandom_range(0, 1));
         drive(8'($urandom), dv, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
               dv && ($urandom_range(0, 9) == 0));
      end
      care_win = 1'b1;

      // Overflow line in the middle of a frame, then reset mid-line
      vs_start();
      check("ovf_clear_vs", 72'(bus.ovf_o), 72'h0);
      line(W, 0, 1'b0, 1'b0);
      line(10, 1, 1'b0, 1'b1);
      line(W, 2, 1'b0, 1'b0);
      check("ovf_sticky", 72'(bus.ovf_o), 72'h1);
      for (int c = 0; c < 4; c++) drive(8'(16*3 + c), 1'b1, 1'b0, 1'b0, 1'b0);
      do_reset();
      check_reset_outputs();
      idle(3);
      frame(4, 1'b0);

      // Frame restart after two lines, with an overflow in the aborted frame
      vs_start();
      line(10, 0, 1'b0, 1'b1);
      line(W, 1, 1'b0, 1'b0);
      check("ovf_before_vs", 72'(bus.ovf_o), 72'h1);
      vs_start();
      check("ovf_after_vs", 72'(bus.ovf_o), 72'h0);
      for (int r = 0; r < 4; r++) line(W, r, 1'b1, 1'b0);

      idle(6);
      check("sb_drain", 72'(exp_q.size()), 72'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
